flash_cfg_loader: RTL and testbench

//  Boot-time and on-demand loader for NUM_HALF 16-bit config halfwords held in SPI flash (IP, MAC, board ID).

---
 rtl/flash_cfg_pkg.sv | 44 ++++
 rtl/flash_cfg_loader_if.sv | 14 +
 rtl/flash_cfg_loader_sc_mux.sv | 38 +++
 rtl/flash_cfg_loader.sv | 184 ++++++++++++++++++
 tb/tb_flash_cfg_loader.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_cfg_pkg.sv
// Shared types and defaults for the flash config loader.
//  - state_t and state encodings for the loader FSM
//  - sc_req_t: SC request payload (port/data/addr/subaddr/op/frame/wr)
//  - default flash port/subaddr/base address
//  - clog2: index width helper, never returns less than 1
package flash_cfg_pkg;

   typedef logic [3:0] state_t;

   localparam state_t BOOT   = 4'd0;
   localparam state_t IDLE   = 4'd1;
   localparam state_t ARB    = 4'd2;
   localparam state_t REQ    = 4'd3;
   localparam state_t REL    = 4'd4;
   localparam state_t TREL   = 4'd5;
   localparam state_t GAP    = 4'd6;
   localparam state_t COMMIT = 4'd7;
   localparam state_t ABORT  = 4'd8;

   localparam logic [15:0] FLASH_PORT_DEF    = 16'h2777;
   localparam logic [31:0] FLASH_SUBADDR_DEF = 32'h000000FF;
   localparam logic [31:0] BASE_ADDR_DEF     = 32'h00FFC000;

   typedef struct packed {
      logic [15:0] port;
      logic [31:0] data;
      logic [31:0] addr;
      logic [31:0] subaddr;
      logic        op;
      logic        frame;
      logic        wr;
   } sc_req_t;

   // Bits needed to hold values 0..n-1 (minimum 1 so n=1 still yields a legal vector).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/flash_cfg_loader_if.sv
// SC bus bundle: request payload toward the slave, ack and reply back.
//  master: drives req, receives ack/rply_data/rply_error
//  slave : receives req, drives ack/rply_data/rply_error
interface flash_cfg_loader_if;
   import flash_cfg_pkg::*;

   sc_req_t     req;
   logic        ack;
   logic [31:0] rply_data;
   logic [31:0] rply_error;

   modport master (output req, input  ack, rply_data, rply_error);
   modport slave  (input  req, output ack, rply_data, rply_error);
endinterface

// File: rtl/flash_cfg_loader_sc_mux.sv
// Combinational SC mux between host and loader, keyed by own_bus.
//  own_bus   in  loader owns the flash port
//  ld_addr   in  flash address of the halfword being read
//  ld_req    in  loader op/frame
//  host      slave side toward the global SC bus
//  flash     master side toward the flash SC slave
module flash_sc_mux
   import flash_cfg_pkg::*;
#(
   parameter logic [15:0] FLASH_PORT    = FLASH_PORT_DEF,
   parameter logic [31:0] FLASH_SUBADDR = FLASH_SUBADDR_DEF
) (
   input  logic        own_bus,
   input  logic [31:0] ld_addr,
   input  logic        ld_req,
   flash_cfg_loader_if.slave  host,
   flash_cfg_loader_if.master flash
);

   sc_req_t own_req;

   // Loader request; write data still follows the host bus.
   always_comb begin
      own_req         = host.req;
      own_req.port    = FLASH_PORT;
      own_req.addr    = ld_addr;
      own_req.subaddr = FLASH_SUBADDR;
      own_req.wr      = 1'b0;
      own_req.op      = ld_req;
      own_req.frame   = ld_req;
   end

   assign flash.req        = own_bus ? own_req : host.req;
   assign host.ack         = own_bus ? 1'b0 : flash.ack;
   assign host.rply_data   = flash.rply_data;
   assign host.rply_error  = flash.rply_error;

endmodule

// File: rtl/flash_cfg_loader.sv
// Boot-time / on-demand loader of NUM_HALF 16-bit config halfwords from SPI flash.
// Owns the flash SC port while loading, otherwise passes host SC traffic through.
//  clk, reset   clock, synchronous active-high reset
//  cfg_reload   1-cycle reload request
//  cfg_out      committed config, halfword i in [16i+15:16i]
//  cfg_valid    a load has committed since reset
//  cfg_update   1-cycle pulse per commit
//  cfg_busy     loader owns the flash bus
//  cfg_error    sticky, last load aborted
//  sc           host SC bus (slave side)
//  flash_sc     flash SC bus (master side)
// Optional macro FLASH_CFG_BLANK_CHECK_EN: an all-16'hFFFF read is aborted instead of committed.
module flash_cfg_loader
   import flash_cfg_pkg::*;
#(
   parameter int unsigned NUM_HALF       = 2,
   parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
   parameter logic [15:0] FLASH_PORT     = FLASH_PORT_DEF,
   parameter logic [31:0] FLASH_SUBADDR  = FLASH_SUBADDR_DEF,
   parameter logic [26:0] BOOT_WAIT      = 27'h4000000,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned MAX_RETRY      = 3,
   parameter logic [31:0] DEFAULT_CFG    = 32'h0aa08479
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_reload,
   output logic [16*NUM_HALF-1:0] cfg_out,
   output logic                  cfg_valid,
   output logic                  cfg_update,
   output logic                  cfg_busy,
   output logic                  cfg_error,
   flash_cfg_loader_if.slave     sc,
   flash_cfg_loader_if.master    flash_sc
);

   localparam int unsigned CFG_W   = 16 * NUM_HALF;
   localparam int unsigned IDX_W   = clog2(NUM_HALF);
   localparam int unsigned RETRY_W = clog2(MAX_RETRY + 1);
   localparam int unsigned CNT_W   = 27;

   localparam logic [CNT_W-1:0]   BOOT_LAST = BOOT_WAIT - 27'd1;
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_HALF - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [RETRY_W-1:0] retry;
   logic [CFG_W-1:0]   shadow;
   logic               last_ok;
   logic               own_bus;
   logic               ld_req;
   logic               pending;

   logic busy_nxt_c, blank_c;
   logic start_c, capture_c, timeout_c, retry_inc_c, advance_c, commit_c, abort_c;

`ifdef FLASH_CFG_BLANK_CHECK_EN
   assign blank_c = (shadow == {CFG_W{1'b1}});
`else
   assign blank_c = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= BOOT;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:   if (cnt == BOOT_LAST) state_nxt = ARB;
         IDLE:   if (cfg_reload || pending) state_nxt = ARB;
         ARB:    if (!sc.req.frame) state_nxt = REQ;
         REQ: begin
            if (flash_sc.ack)         state_nxt = REL;
            else if (cnt == TO_LAST)  state_nxt = TREL;
         end
         REL:    if (!flash_sc.ack) state_nxt = GAP;
         TREL:   if (!flash_sc.ack) state_nxt = (retry == RETRY_MAX) ? ABORT : GAP;
         GAP:    if (cnt == GAP_LAST) state_nxt = (last_ok && idx == IDX_LAST) ? COMMIT : REQ;
         COMMIT: state_nxt = IDLE;
         ABORT:  state_nxt = IDLE;
         default: state_nxt = BOOT;
      endcase
   end

   // Output/strobe decode per state.
   always_comb begin
      start_c     = 1'b0;
      capture_c   = 1'b0;
      timeout_c   = 1'b0;
      retry_inc_c = 1'b0;
      advance_c   = 1'b0;
      commit_c    = 1'b0;
      abort_c     = 1'b0;
      case (state)
         ARB:  start_c = !sc.req.frame;
         REQ: begin
            capture_c = flash_sc.ack;
            timeout_c = !flash_sc.ack && (cnt == TO_LAST);
         end
         TREL: retry_inc_c = !flash_sc.ack && (retry != RETRY_MAX);
         GAP:  advance_c = (cnt == GAP_LAST) && last_ok && (idx != IDX_LAST);
         COMMIT: begin
            commit_c = !blank_c;
            abort_c  = blank_c;
         end
         ABORT: abort_c = 1'b1;
         default: ;
      endcase
   end

   assign busy_nxt_c = !(state_nxt inside {BOOT, IDLE, ARB});

   // Datapath: counters, shadow buffer, committed config.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         retry      <= '0;
         shadow     <= '0;
         last_ok    <= 1'b0;
         own_bus    <= 1'b0;
         ld_req     <= 1'b0;
         pending    <= 1'b0;
         cfg_out    <= CFG_W'(DEFAULT_CFG);
         cfg_valid  <= 1'b0;
         cfg_update <= 1'b0;
         cfg_error  <= 1'b0;
      end else begin
         // One shared counter, restarted on every state change.
         cnt        <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         own_bus    <= busy_nxt_c;
         ld_req     <= (state_nxt == REQ);
         cfg_update <= commit_c;

         if (start_c) begin
            idx   <= '0;
            retry <= '0;
         end
         if (capture_c) begin
            shadow[16*int'(idx) +: 16] <= flash_sc.rply_data[15:0];
            last_ok <= 1'b1;
         end
         if (timeout_c)   last_ok <= 1'b0;
         if (retry_inc_c) retry <= retry + RETRY_W'(1);
         if (advance_c) begin
            idx   <= idx + IDX_W'(1);
            retry <= '0;
         end
         if (commit_c) begin
            cfg_out   <= shadow;
            cfg_valid <= 1'b1;
            cfg_error <= 1'b0;
         end
         if (abort_c) cfg_error <= 1'b1;

         // Reloads during a load collapse into one; IDLE consumes it.
         if (own_bus && cfg_reload) pending <= 1'b1;
         else if (state == IDLE)    pending <= 1'b0;
      end
   end

   assign cfg_busy = own_bus;

   flash_sc_mux #(
      .FLASH_PORT    (FLASH_PORT),
      .FLASH_SUBADDR (FLASH_SUBADDR)
   ) u_mux (
      .own_bus (own_bus),
      .ld_addr (BASE_ADDR + 32'(idx)),
      .ld_req  (ld_req),
      .host    (sc),
      .flash   (flash_sc)
   );

endmodule

// File: tb/tb_flash_cfg_loader.sv
// Self-checking bench for flash_cfg_loader with a behavioural flash slave
// (ack after ack_dly cycles, reply {16'h0, mem[addr-BASE]}, per-halfword ack suppression).
module tb_flash_cfg_loader;
   import flash_cfg_pkg::*;

   localparam int unsigned NUM_HALF   = 2;
   localparam logic [31:0] BASE       = 32'h00FFC000;
   localparam logic [26:0] BOOT_WAIT  = 27'd100;
   localparam int unsigned GAP_CYCLES = 16;
   localparam int unsigned TIMEOUT    = 256;
   localparam int unsigned MAX_RETRY  = 3;
   localparam logic [31:0] DEF_CFG    = 32'h0aa08479;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_reload;
   logic [31:0] cfg_out;
   logic        cfg_valid, cfg_update, cfg_busy, cfg_error;

   always #5 clk = ~clk;

   flash_cfg_loader_if host_if ();
   flash_cfg_loader_if flash_if ();

   flash_cfg_loader #(
      .NUM_HALF       (NUM_HALF),
      .BASE_ADDR      (BASE),
      .FLASH_PORT     (16'h2777),
      .FLASH_SUBADDR  (32'h000000FF),
      .BOOT_WAIT      (BOOT_WAIT),
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT),
      .MAX_RETRY      (MAX_RETRY),
      .DEFAULT_CFG    (DEF_CFG)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_reload (cfg_reload),
      .cfg_out    (cfg_out),
      .cfg_valid  (cfg_valid),
      .cfg_update (cfg_update),
      .cfg_busy   (cfg_busy),
      .cfg_error  (cfg_error),
      .sc         (host_if),
      .flash_sc   (flash_if)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- flash slave model ----------------
   logic [15:0] mem   [64];
   int          sup_n [64];
   int          seen  [64];
   int          ack_dly = 3;
   int          f_cnt = 0;
   logic        f_sup = 1'b0;
   logic        f_ack = 1'b0;
   logic [31:0] f_rdata = '0;

   function automatic int hw_of(input logic [31:0] a);
      logic [31:0] d;
      d = a - BASE;
      return (d < 32'd64) ? int'(d) : 63;
   endfunction

   always @(posedge clk) begin
      if (!flash_if.req.frame) begin
         f_cnt <= 0;
         f_ack <= 1'b0;
      end else begin
         f_cnt <= f_cnt + 1;
         if (f_cnt == 0) begin
            f_sup <= (seen[hw_of(flash_if.req.addr)] < sup_n[hw_of(flash_if.req.addr)]);
            seen[hw_of(flash_if.req.addr)] <= seen[hw_of(flash_if.req.addr)] + 1;
         end
         if (f_cnt >= ack_dly && !f_sup) begin
            f_ack   <= 1'b1;
            f_rdata <= {16'h0, mem[hw_of(flash_if.req.addr)]};
         end
      end
   end

   assign flash_if.ack        = f_ack;
   assign flash_if.rply_data  = f_rdata;
   assign flash_if.rply_error = 32'h0;

   // ---------------- monitors ----------------
   int          upd_cnt = 0;
   int          flen = 0;
   logic [31:0] cur_addr = '0;
   int          fl_len  [$];
   logic [31:0] fl_addr [$];

   always @(posedge clk) begin
      if (cfg_update) upd_cnt <= upd_cnt + 1;
      if (flash_if.req.frame) begin
         flen     <= flen + 1;
         cur_addr <= flash_if.req.addr;
      end else if (flen != 0) begin
         fl_len.push_back(flen);
         fl_addr.push_back(cur_addr);
         flen <= 0;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_cfg;
   logic        exp_valid, exp_err;

   function automatic void model_reset();
      exp_cfg   = DEF_CFG;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
   endfunction

   // Outcome of one load: sup_cnt = consecutive ack-less attempts on one halfword.
   function automatic bit model_load(input int sup_cnt);
      logic [31:0] d;
      bit ok;
      d  = {mem[1], mem[0]};
      ok = (sup_cnt <= int'(MAX_RETRY));
`ifdef FLASH_CFG_BLANK_CHECK_EN
      if (d == 32'hFFFF_FFFF) ok = 1'b0;
`endif
      if (ok) begin
         exp_cfg   = d;
         exp_valid = 1'b1;
         exp_err   = 1'b0;
      end else begin
         exp_err = 1'b1;
      end
      return ok;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reload();
      cfg_reload = 1'b1;
      tick(1);
      cfg_reload = 1'b0;
   endtask

   task automatic randomize_mem();
      mem[0] = 16'($urandom);
      mem[1] = 16'($urandom);
      ack_dly = int'($urandom_range(1, 6));
   endtask

   // Waits for busy to rise and fall; ok=0 if the budget runs out.
   task automatic wait_load(input int budget, output bit ok);
      int n;
      n = 0;
      while (cfg_busy !== 1'b1 && n < budget) begin tick(1); n++; end
      while (cfg_busy !== 1'b0 && n < budget) begin tick(1); n++; end
      ok = (n < budget);
      tick(2);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      cfg_reload = 1'b0;
      host_if.req = '0;
      tick(3);
      model_reset();
      total++; if (cfg_out !== exp_cfg) begin bad++; $display("FAIL reset_cfg_out: got %h want %h", cfg_out, exp_cfg); end
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", cfg_valid); end
      total++; if (cfg_update !== 1'b0) begin bad++; $display("FAIL reset_update: got %b want 0", cfg_update); end
      total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
      total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", cfg_error); end
      total++; if (flash_if.req.frame !== 1'b0) begin bad++; $display("FAIL reset_frame: got %b want 0", flash_if.req.frame); end
   endtask

   task automatic test_boot_load();
      int c, u0;
      bit ok;
      bit commit;
      randomize_mem();
      u0 = upd_cnt;
      reset = 1'b0;
      c = 0;
      while (cfg_busy !== 1'b1 && c < 1000) begin tick(1); c++; end
      total++; if (c < int'(BOOT_WAIT) || c > int'(BOOT_WAIT) + 3) begin
         bad++; $display("FAIL boot_wait: busy after %0d cycles want %0d..%0d", c, BOOT_WAIT, BOOT_WAIT + 3);
      end
      total++; if (flash_if.req.port !== 16'h2777 || flash_if.req.addr !== BASE || flash_if.req.wr !== 1'b0
                   || flash_if.req.subaddr !== 32'hFF) begin
         bad++; $display("FAIL boot_bus: port %h addr %h sub %h wr %b want 2777 %h ff 0",
                         flash_if.req.port, flash_if.req.addr, flash_if.req.subaddr, flash_if.req.wr, BASE);
      end
      wait_load(2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL boot_done: load did not finish, busy=%b", cfg_busy); end
      commit = model_load(0);
      total++; if (cfg_out !== exp_cfg) begin bad++; $display("FAIL boot_cfg_out: got %h want %h", cfg_out, exp_cfg); end
      total++; if (cfg_valid !== exp_valid) begin bad++; $display("FAIL boot_valid: got %b want %b", cfg_valid, exp_valid); end
      total++; if (upd_cnt - u0 != int'(commit)) begin bad++; $display("FAIL boot_updates: got %0d want %0d", upd_cnt - u0, int'(commit)); end
   endtask

   task automatic test_host_arb();
      int n;
      bit ok;
      bit commit;
      logic [31:0] hdata;
      reset = 1'b1;
      tick(2);
      model_reset();
      randomize_mem();
      mem[16] = 16'($urandom);
      reset = 1'b0;
      tick(50);
      hdata = $urandom;
      host_if.req.port    = 16'h1234;
      host_if.req.addr    = BASE + 32'h10;
      host_if.req.subaddr = 32'h55;
      host_if.req.data    = hdata;
      host_if.req.wr      = 1'b0;
      host_if.req.op      = 1'b1;
      host_if.req.frame   = 1'b1;
      tick(1);
      total++; if (flash_if.req.port !== 16'h1234 || flash_if.req.addr !== BASE + 32'h10 || flash_if.req.data !== hdata) begin
         bad++; $display("FAIL host_pass: port %h addr %h data %h want 1234 %h %h",
                         flash_if.req.port, flash_if.req.addr, flash_if.req.data, BASE + 32'h10, hdata);
      end
      n = 0;
      while (host_if.ack !== 1'b1 && n < 50) begin tick(1); n++; end
      total++; if (host_if.ack !== 1'b1) begin bad++; $display("FAIL host_ack: got %b want 1", host_if.ack); end
      total++; if (host_if.rply_data !== {16'h0, mem[16]}) begin
         bad++; $display("FAIL host_rply: got %h want %h", host_if.rply_data, {16'h0, mem[16]});
      end
      tick(int'(BOOT_WAIT) + 50 - n);
      total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL host_hold: busy=%b want 0 while host frame open", cfg_busy); end
      host_if.req = '0;
      wait_load(2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL host_load_done: load did not finish, busy=%b", cfg_busy); end
      commit = model_load(0);
      total++; if (cfg_out !== exp_cfg || commit != 1'b1) begin bad++; $display("FAIL host_cfg_out: got %h want %h", cfg_out, exp_cfg); end
   endtask

   task automatic test_timeout_abort();
      int mark, nf, u0;
      bit ok;
      bit commit;
      reset = 1'b1;
      tick(2);
      model_reset();
      randomize_mem();
      sup_n[1] = seen[1] + 1000;
      mark = fl_len.size();
      u0 = upd_cnt;
      reset = 1'b0;
      wait_load(8000, ok);
      sup_n[1] = 0;
      total++; if (!ok) begin bad++; $display("FAIL to_done: load did not finish, busy=%b", cfg_busy); end
      commit = model_load(1000);
      nf = 0;
      for (int i = mark; i < fl_len.size(); i++) begin
         if (fl_addr[i] == BASE + 32'd1) begin
            nf++;
            total++; if (fl_len[i] != int'(TIMEOUT)) begin
               bad++; $display("FAIL to_frame_len: frame %0d len %0d want %0d", nf, fl_len[i], TIMEOUT);
            end
         end
      end
      total++; if (nf != int'(MAX_RETRY) + 1) begin bad++; $display("FAIL to_frames: got %0d want %0d", nf, MAX_RETRY + 1); end
      total++; if (cfg_error !== exp_err) begin bad++; $display("FAIL to_error: got %b want %b", cfg_error, exp_err); end
      total++; if (cfg_out !== exp_cfg) begin bad++; $display("FAIL to_cfg_out: got %h want %h", cfg_out, exp_cfg); end
      total++; if (cfg_valid !== exp_valid) begin bad++; $display("FAIL to_valid: got %b want %b", cfg_valid, exp_valid); end
      total++; if (upd_cnt - u0 != int'(commit)) begin bad++; $display("FAIL to_updates: got %0d want %0d", upd_cnt - u0, int'(commit)); end
   endtask

   task automatic test_retry();
      int k, mark, nf;
      bit ok;
      bit commit;
      randomize_mem();
      k = int'($urandom_range(0, 1));
      sup_n[k] = seen[k] + 1;
      mark = fl_len.size();
      pulse_reload();
      wait_load(4000, ok);
      sup_n[k] = 0;
      total++; if (!ok) begin bad++; $display("FAIL retry_done: load did not finish, busy=%b", cfg_busy); end
      commit = model_load(1);
      nf = 0;
      for (int i = mark; i < fl_len.size(); i++) if (fl_addr[i] == BASE + 32'(k)) nf++;
      total++; if (nf != 2) begin bad++; $display("FAIL retry_frames: hw%0d frames %0d want 2", k, nf); end
      total++; if (cfg_error !== exp_err) begin bad++; $display("FAIL retry_error: got %b want %b", cfg_error, exp_err); end
      total++; if (cfg_out !== exp_cfg || !commit) begin bad++; $display("FAIL retry_cfg_out: got %h want %h", cfg_out, exp_cfg); end
      total++; if (cfg_valid !== exp_valid) begin bad++; $display("FAIL retry_valid: got %b want %b", cfg_valid, exp_valid); end
   endtask

   task automatic test_back_to_back();
      int n, u0;
      bit ok;
      bit commit;
      randomize_mem();
      u0 = upd_cnt;
      pulse_reload();
      n = 0;
      while (cfg_busy !== 1'b1 && n < 100) begin tick(1); n++; end
      for (int i = 0; i < 3; i++) begin
         tick(3);
         pulse_reload();
      end
      n = 0;
      while (cfg_busy !== 1'b0 && n < 2000) begin tick(1); n++; end
      commit = model_load(0);
      total++; if (cfg_out !== exp_cfg || !commit) begin bad++; $display("FAIL b2b_first: got %h want %h", cfg_out, exp_cfg); end
      mem[0] = 16'h1234;
      mem[1] = 16'h5678;
      wait_load(2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_second_done: second load missing, busy=%b", cfg_busy); end
      commit = model_load(0);
      tick(150);
      total++; if (cfg_out !== 32'h56781234) begin bad++; $display("FAIL b2b_cfg_out: got %h want 56781234", cfg_out); end
      total++; if (upd_cnt - u0 != 2 || cfg_busy !== 1'b0) begin
         bad++; $display("FAIL b2b_updates: got %0d busy %b want 2 busy 0", upd_cnt - u0, cfg_busy);
      end
   endtask

   task automatic test_random_loads();
      int h, s, u0;
      bit ok;
      bit commit;
      for (int it = 0; it < 4; it++) begin
         randomize_mem();
         h = int'($urandom_range(0, 1));
         s = int'($urandom_range(0, MAX_RETRY + 1));
         sup_n[h] = seen[h] + s;
         u0 = upd_cnt;
         pulse_reload();
         wait_load(6000, ok);
         sup_n[h] = 0;
         commit = model_load(s);
         total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done: load did not finish", it); end
         total++; if (cfg_out !== exp_cfg || cfg_error !== exp_err || cfg_valid !== exp_valid) begin
            bad++; $display("FAIL rnd%0d_result: hw%0d sup%0d got %h/%b/%b want %h/%b/%b", it, h, s,
                            cfg_out, cfg_error, cfg_valid, exp_cfg, exp_err, exp_valid);
         end
         total++; if (upd_cnt - u0 != int'(commit)) begin bad++; $display("FAIL rnd%0d_updates: got %0d want %0d", it, upd_cnt - u0, int'(commit)); end
      end
   endtask

   task automatic test_reset_mid_load();
      int n;
      bit ok;
      bit commit;
      randomize_mem();
      ack_dly = 6;
      pulse_reload();
      n = 0;
      while (!(cfg_busy === 1'b1 && flash_if.req.frame === 1'b1) && n < 200) begin tick(1); n++; end
      total++; if (flash_if.req.frame !== 1'b1) begin bad++; $display("FAIL mid_frame_seen: frame=%b want 1", flash_if.req.frame); end
      reset = 1'b1;
      tick(1);
      model_reset();
      total++; if (flash_if.req.frame !== 1'b0) begin bad++; $display("FAIL mid_frame_drop: got %b want 0", flash_if.req.frame); end
      total++; if (cfg_out !== exp_cfg || cfg_valid !== 1'b0 || cfg_busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset_state: cfg %h valid %b busy %b want %h 0 0", cfg_out, cfg_valid, cfg_busy, exp_cfg);
      end
      tick(2);
      reset = 1'b0;
      wait_load(2000, ok);
      commit = model_load(0);
      total++; if (!ok || cfg_out !== exp_cfg || !commit) begin bad++; $display("FAIL mid_reboot: got %h want %h", cfg_out, exp_cfg); end
   endtask

   task automatic test_blank();
      int u0;
      bit ok;
      bit commit;
      mem[0] = 16'hFFFF;
      mem[1] = 16'hFFFF;
      u0 = upd_cnt;
      pulse_reload();
      wait_load(2000, ok);
      commit = model_load(0);
      total++; if (!ok) begin bad++; $display("FAIL blank_done: load did not finish"); end
      total++; if (cfg_out !== exp_cfg || cfg_error !== exp_err || cfg_valid !== exp_valid) begin
         bad++; $display("FAIL blank_result: got %h/%b/%b want %h/%b/%b", cfg_out, cfg_error, cfg_valid, exp_cfg, exp_err, exp_valid);
      end
      total++; if (upd_cnt - u0 != int'(commit)) begin bad++; $display("FAIL blank_updates: got %0d want %0d", upd_cnt - u0, int'(commit)); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]   = 16'(i * 16'h0101);
         sup_n[i] = 0;
      end
      host_if.req = '0;
      cfg_reload  = 1'b0;
      reset       = 1'b1;
      test_reset();
      test_boot_load();
      test_host_arb();
      test_timeout_abort();
      test_retry();
      test_back_to_back();
      test_random_loads();
      test_reset_mid_load();
      test_blank();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
